// File: rtl/semaforo.sv
// -----------------------------------------------------------------------------
// semaforo: two-way intersection traffic-light controller.
//
// The cycle is A green, A yellow, B green, B yellow, then back to A green.
// Each phase lasts a fixed number of clocks set by a parameter. A request
// button (bt) cuts A green short so that B is served early.
//
// Optional feature (compile-time macro ALL_RED_EN):
//   When defined, a one-cycle all-red state is inserted after each yellow
//   (A_Y -> all red -> B_G and B_Y -> all red -> A_G).
//   When undefined, there is no all-red state.
//
// Parameters:
//   T_VERDE    cycles A stays green (a value of 0 behaves as 1)
//   T_AMARELO  cycles each yellow lasts, A and B (a value of 0 behaves as 1)
//   T_VERMELHO cycles B stays green while A is red (a value of 0 behaves as 1)
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous reset, active low
//   bt   in   request button, active high, sampled on each rising edge
//   A    out  light A, one-hot: 001 green, 010 yellow, 100 red
//   B    out  light B, same encoding as A
// -----------------------------------------------------------------------------
module semaforo #(
    parameter logic [7:0] T_VERDE    = 8'd3,
    parameter logic [7:0] T_AMARELO  = 8'd1,
    parameter logic [7:0] T_VERMELHO = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b100;

    // Terminal counter value per phase; a duration of 0 is treated as 1.
    localparam logic [7:0] LAST_VERDE    = (T_VERDE    == 8'd0) ? 8'd0 : T_VERDE    - 8'd1;
    localparam logic [7:0] LAST_AMARELO  = (T_AMARELO  == 8'd0) ? 8'd0 : T_AMARELO  - 8'd1;
    localparam logic [7:0] LAST_VERMELHO = (T_VERMELHO == 8'd0) ? 8'd0 : T_VERMELHO - 8'd1;

`ifdef ALL_RED_EN
    // Two distinct all-red states so each one knows which road comes next.
    typedef enum logic [2:0] {
        A_G   = 3'd0,
        A_Y   = 3'd1,
        B_G   = 3'd2,
        B_Y   = 3'd3,
        AR_AB = 3'd4,
        AR_BA = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        A_G = 3'd0,
        A_Y = 3'd1,
        B_G = 3'd2,
        B_Y = 3'd3
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_q, req_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= A_G;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        req_d   = req_q | bt;

        case (state_q)
            // A registered request ends A green on the next edge.
            A_G: if (req_q || (cnt_q == LAST_VERDE)) state_d = A_Y;
`ifdef ALL_RED_EN
            A_Y:   if (cnt_q == LAST_AMARELO)  state_d = AR_AB;
            B_G:   if (cnt_q == LAST_VERMELHO) state_d = B_Y;
            B_Y:   if (cnt_q == LAST_AMARELO)  state_d = AR_BA;
            AR_AB: state_d = B_G;
            AR_BA: state_d = A_G;
`else
            A_Y:   if (cnt_q == LAST_AMARELO)  state_d = B_G;
            B_G:   if (cnt_q == LAST_VERMELHO) state_d = B_Y;
            B_Y:   if (cnt_q == LAST_AMARELO)  state_d = A_G;
`endif
            default: state_d = A_G;
        endcase

        if (state_d != state_q) cnt_d = 8'd0;

        // Serving B satisfies the request; this clear overrides a press
        // sampled on the same edge.
        if ((state_d == B_G) && (state_q != B_G)) req_d = 1'b0;
    end

    // Moore decode from the state register only, so outputs cannot glitch
    // on bt. Unlisted states fall back to all red.
    always_comb begin
        A = RED;
        B = RED;
        case (state_q)
            A_G:     begin A = GREEN;  B = RED;    end
            A_Y:     begin A = YELLOW; B = RED;    end
            B_G:     begin A = RED;    B = GREEN;  end
            B_Y:     begin A = RED;    B = YELLOW; end
            default: begin A = RED;    B = RED;    end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
module tb_semaforo;

    localparam logic [7:0] TV = 8'd3;
    localparam logic [7:0] TA = 8'd1;
    localparam logic [7:0] TR = 8'd2;

    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] R  = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bt  = 1'b0;
    logic [2:0] A, B;

    semaforo #(.T_VERDE(TV), .T_AMARELO(TA), .T_VERMELHO(TR)) dut (
        .clk(clk), .rst(rst), .bt(bt), .A(A), .B(B)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the cycle as a list of phases, each with a duration
    // and the pair of lights shown, walked by index.
`ifdef ALL_RED_EN
    localparam int NPH  = 6;
    localparam int BGI  = 3;
    localparam int PLEN = 9;
`else
    localparam int NPH  = 4;
    localparam int BGI  = 2;
    localparam int PLEN = 7;
`endif
    int         dur [NPH];
    logic [2:0] la  [NPH];
    logic [2:0] lb  [NPH];
    int         ph, tin;
    bit         mreq;
    bit         cmp_model = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
    } vec_t;
    vec_t tbl[$];

    function automatic int eff(input logic [7:0] p);
        return (p == 8'd0) ? 1 : int'(p);
    endfunction

    task automatic model_reset();
        ph = 0; tin = 0; mreq = 0;
    endtask

    task automatic model_step(input bit b);
        bit leave;
        int nxt;
        leave = (tin + 1 >= dur[ph]) || (ph == 0 && mreq);
        nxt   = leave ? (ph + 1) % NPH : ph;
        mreq  = mreq | b;
        if (leave && nxt == BGI) mreq = 0;
        tin   = leave ? 0 : tin + 1;
        ph    = nxt;
    endtask

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One rising edge; outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step(bt);
        #1;
        if (cmp_model) begin
            chk("model_A", A, la[ph]);
            chk("model_B", B, lb[ph]);
            chk_int("never_both_go", int'(A == R || B == R), 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bt  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic wait_for(input string nm, input logic [2:0] ea, input logic [2:0] eb);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (A == ea && B == eb) begin ok = 1; break; end
            step();
        end
        chk_int(nm, int'(ok), 1);
    endtask

    // Number of consecutive samples (cycles) with A green, starting now.
    task automatic green_len(output int n);
        n = 0;
        while (A == G && n < 300) begin
            n++;
            step();
        end
    endtask

    logic [2:0] pa [PLEN];
    logic [2:0] pb [PLEN];

    initial begin
        int n;

`ifdef ALL_RED_EN
        dur = '{eff(TV), eff(TA), 1, eff(TR), eff(TA), 1};
        la  = '{G, Y, R, R, R, R};
        lb  = '{R, R, R, G, Y, R};
        pa  = '{G, G, Y, R, R, R, R, R, G};
        pb  = '{R, R, R, R, G, G, Y, R, R};
`else
        dur = '{eff(TV), eff(TA), eff(TR), eff(TA)};
        la  = '{G, Y, R, R};
        lb  = '{R, R, G, Y};
        pa  = '{G, G, Y, R, R, R, G};
        pb  = '{R, R, R, G, G, Y, R};
`endif
        // Free-run table: lights after each edge from reset, two periods.
        for (int k = 0; k < 2 * PLEN; k++) tbl.push_back('{pa[k % PLEN], pb[k % PLEN]});
        model_reset();

        // Reset held: lights stay in the reset pattern through clock edges.
        #1;
        chk("rst_A", A, G);
        chk("rst_B", B, R);
        for (int k = 0; k < 3; k++) step();
        chk("rst_hold_A", A, G);
        chk("rst_hold_B", B, R);
        rst = 1'b1;
        model_reset();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            n++;
            if (A == Y) break;
        end
        chk_int("first_yellow_edge", n, 3);

        // Free run with bt low.
        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            step();
            chk($sformatf("tbl_A[%0d]", k), A, tbl[k].a);
            chk($sformatf("tbl_B[%0d]", k), B, tbl[k].b);
        end

        // Press sampled at edge 1 shortens A green to 2 cycles.
        do_reset();
        bt = 1'b1;
        step();
        bt = 1'b0;
        chk("bt_e1_A", A, G);
        step();
        chk("bt_e2_A", A, Y);
        wait_for("bt_reach_bg", R, G);
        wait_for("bt_back_ag", G, R);
        green_len(n);
        chk_int("bt_req_cleared_green", n, 3);

        // Press sampled on the edge leaving A_Y is cleared on entry to B_G.
        wait_for("entry_reach_ay", Y, R);
        bt = 1'b1;
        step();
        bt = 1'b0;
        wait_for("entry_back_ag", G, R);
        green_len(n);
        chk_int("entry_press_green", n, 3);

        // Press during B_Y: next A green lasts one cycle.
        wait_for("by_reach", R, Y);
        bt = 1'b1;
        step();
        bt = 1'b0;
        wait_for("by_back_ag", G, R);
        green_len(n);
        chk_int("by_press_green", n, 1);
        chk("by_then_yellow", A, Y);

        // Async reset mid-B_G after a press that set req.
        wait_for("ar_reach_bg", R, G);
        bt = 1'b1;
        step();
        bt = 1'b0;
        chk("ar_still_bg", B, G);
        #2;
        rst = 1'b0;
        #1;
        chk("async_A", A, G);
        chk("async_B", B, R);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        green_len(n);
        chk_int("async_green_len", n, 3);
        chk("async_then_yellow", A, Y);

        // Random button traffic against the phase-table model, with the
        // occasional asynchronous reset between edges.
        do_reset();
        cmp_model = 1;
        for (int k = 0; k < 800; k++) begin
            bt = ($urandom_range(0, 4) == 0);
            step();
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                chk("rand_async_A", A, G);
                chk("rand_async_B", B, R);
                model_reset();
                #1;
                rst = 1'b1;
            end
        end
        cmp_model = 0;
        bt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
